// File: rtl/pc_fetch.sv
// Program counter and single-outstanding instruction fetch for the multicycle core.
// Optional misaligned-target trap is enabled with `define FETCH_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | reset state, issues the first request on the next cycle
// REQ   | fetch request presented at imem_addr = pc
// WAIT  | request accepted, waiting for the instruction word
// HOLD  | instruction held for decode until retire
`timescale 1ns/1ps
module pc_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0040_0000
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  next_pc_select,
   input  logic [31:0] immediate,
   input  logic [31:0] rs1_value,
   input  logic        retire,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus_4,
   output logic        trap_misaligned
);

   localparam logic [1:0]  CTL_PC_PC4     = 2'b00;
   localparam logic [1:0]  CTL_PC_PC_IMM  = 2'b01;
   localparam logic [1:0]  CTL_PC_RS1_IMM = 2'b10;
   localparam logic [31:0] INST_NOP       = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] target;
   logic [31:0] rs1_sum;

   assign imem_addr = pc;
   assign pc_plus_4 = pc + 32'd4;

   // 2'b11 falls into the default arm and behaves as pc+4
   always_comb begin
      rs1_sum = rs1_value + immediate;
      case (next_pc_select)
         CTL_PC_PC4:     target = pc_plus_4;
         CTL_PC_PC_IMM:  target = pc + immediate;
         CTL_PC_RS1_IMM: target = {rs1_sum[31:1], 1'b0};
         default:        target = pc_plus_4;
      endcase
   end

`ifndef FETCH_MISALIGN_TRAP_EN
   assign trap_misaligned = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         inst           <= INST_NOP;
         inst_valid     <= 1'b0;
         imem_req_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_misaligned <= 1'b0;
`endif
      end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_misaligned <= 1'b0;
`endif
         case (state)
            IDLE: begin
               state          <= REQ;
               imem_req_valid <= 1'b1;
            end
            REQ: begin
               if (imem_req_ready) begin
                  state          <= WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (imem_resp_valid) begin
                  state      <= HOLD;
                  inst       <= imem_resp_data;
                  inst_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (retire) begin
                  state          <= REQ;
                  inst_valid     <= 1'b0;
                  imem_req_valid <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (target[1:0] != 2'b00) begin
                     pc              <= TRAP_VECTOR;
                     trap_misaligned <= 1'b1;
                  end else begin
                     pc <= target;
                  end
`else
                  pc <= target & 32'hFFFF_FFFC;
`endif
               end
            end
            default: begin
               state          <= IDLE;
               inst_valid     <= 1'b0;
               imem_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
